// File: rtl/radix2_divider_pkg.sv
// radix2_divider shared types and widths.
// Build option: RADIX2_DIVIDER_EARLY_EXIT_EN.
package radix2_divider_pkg;

  localparam int DEF_BIT    = 8;
  localparam int BIT        = DEF_BIT;
  localparam int DIVIDEND_W = 2 * BIT - 1;
  localparam int REM_W      = BIT + 1;
  localparam int CNT_W      = $clog2(2 * BIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/radix2_divider_if.sv
// radix2_divider operand/result handshake bundle.
// Build option: RADIX2_DIVIDER_EARLY_EXIT_EN.
interface radix2_divider_if #(
  parameter int BIT = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [2*BIT-2:0] dividend;
  logic [BIT-1:0]   divisor;
  logic             out_valid;
  logic             out_ready;
  logic [2*BIT-2:0] quotient;
  logic [BIT-1:0]   remainder;
  logic             div_by_zero;

  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/radix2_divider_div_step.sv
// One restoring-division step, purely combinational.
// Build option: RADIX2_DIVIDER_EARLY_EXIT_EN.
module div_step #(
  parameter int BIT = 8
) (
  input  logic [BIT:0]   rem_i,
  input  logic           bit_i,
  input  logic [BIT-1:0] divisor_i,
  output logic [BIT:0]   rem_o,
  output logic           qbit_o
);

  logic [BIT+1:0] sh;
  logic [BIT:0]   df;

  assign sh     = {rem_i, bit_i};
  assign qbit_o = sh >= {2'b00, divisor_i};
  // true difference is below divisor, so modulo width is exact
  assign df     = sh[BIT:0] - {1'b0, divisor_i};
  assign rem_o  = qbit_o ? df : sh[BIT:0];

endmodule

// File: rtl/radix2_divider.sv
// radix2_divider: sequential restoring divider, MSB first.
// Build option: RADIX2_DIVIDER_EARLY_EXIT_EN (dividend<divisor finishes at once).
module radix2_divider
  import radix2_divider_pkg::*;
#(
  parameter int BIT = DEF_BIT
) (
  input  logic            clock,
  input  logic            reset,
  radix2_divider_if.slave bus
);

  localparam int DW = 2 * BIT - 1;
  localparam int RW = BIT + 1;
  localparam int CW = $clog2(2 * BIT);
  localparam logic [CW-1:0] CNT_INIT = CW'(DW);

  state_e          state_q, state_d;
  logic [DW-1:0]   wrk_q, wrk_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [RW-1:0]   step_rem;
  logic [BIT-1:0]  dvs_q, dvs_d;
  logic [BIT-1:0]  rmd_q, rmd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dbz_q, dbz_d;
  logic            step_qbit;
  logic            idle;
  logic            done;
  logic            early;

  div_step #(
    .BIT(BIT)
  ) u_step (
    .rem_i    (rem_q),
    .bit_i    (wrk_q[DW-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .qbit_o   (step_qbit)
  );

`ifdef RADIX2_DIVIDER_EARLY_EXIT_EN
  assign early = bus.dividend < DW'(bus.divisor);
`else
  assign early = 1'b0;
`endif

  assign bus.in_ready    = idle & ~reset;
  assign bus.out_valid   = done;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;

  // next-state, datapath and handshake decode
  always_comb begin
    state_d = state_q;
    wrk_d   = wrk_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    idle    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle = 1'b1;
        if (bus.in_valid) begin
          dvs_d = bus.divisor;
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rmd_d   = bus.dividend[BIT-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end else if (early) begin
            quo_d   = '0;
            rmd_d   = bus.dividend[BIT-1:0];
            dbz_d   = 1'b0;
            state_d = DONE;
          end else begin
            wrk_d   = bus.dividend;
            rem_d   = '0;
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        wrk_d = {wrk_q[DW-2:0], step_qbit};
        rem_d = step_rem;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          quo_d   = {wrk_q[DW-2:0], step_qbit};
          rmd_d   = step_rem[BIT-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // operand, working and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wrk_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      wrk_q <= wrk_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      dbz_q <= dbz_d;
    end
  end

endmodule

// File: tb/tb_radix2_divider.sv
// Directed bench for radix2_divider (BIT=8).
// Build option: RADIX2_DIVIDER_EARLY_EXIT_EN changes small-operand latency.
module tb_radix2_divider;
  import radix2_divider_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  radix2_divider_if #(.BIT(8)) bus ();

  radix2_divider #(
    .BIT(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // accept edge counts as edge 1; returns edges until out_valid
  task automatic accept_wait(output int lat, output bit rdy_seen);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 64) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic consume(string tag);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_idle_ov"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic drive(int dvd, int dvs);
    bus.dividend = 15'(dvd);
    bus.divisor  = 8'(dvs);
    bus.in_valid = 1'b1;
  endtask

  task automatic op(string tag, int dvd, int dvs,
                    int eq, int er, int ez, int el);
    int lat;
    bit rs;
    drive(dvd, dvs);
    accept_wait(lat, rs);
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(el));
    chk({tag, "_busyrdy"}, 32'(rs), 32'd0);
    chk({tag, "_q"}, 32'(bus.quotient), 32'(eq));
    chk({tag, "_r"}, 32'(bus.remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
    consume(tag);
  endtask

  function automatic int small_lat(int dvd, int dvs);
`ifdef RADIX2_DIVIDER_EARLY_EXIT_EN
    if (dvd < dvs) return 1;
`endif
    return 16;
  endfunction

  initial begin
    int lat;
    bit rs;
    int a, b, d, q, r;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_rdy", 32'(bus.in_ready), 32'd0);
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_q", 32'(bus.quotient), 32'd0);
    chk("rst_r", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_rdy_idle", 32'(bus.in_ready), 32'd1);

    op("basic", 200, 7, 28, 4, 0, 16);
    op("max_1", 32767, 1, 32767, 0, 0, 16);
    op("max_255", 32767, 255, 128, 127, 0, 16);
    op("zero_9", 0, 9, 0, 0, 0, small_lat(0, 9));
    op("six_9", 6, 9, 0, 6, 0, small_lat(6, 9));
    op("dbz", 1234, 0, 32'h7FFF, 32'hD2, 1, 1);
    op("after_dbz", 1234, 2, 617, 0, 0, 16);

    // backpressure with a second request waiting
    drive(1000, 10);
    accept_wait(lat, rs);
    chk("bp_lat", 32'(lat), 32'd16);
    drive(77, 5);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("bp_ov", 32'(bus.out_valid), 32'd1);
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
      chk("bp_q", 32'(bus.quotient), 32'd100);
      chk("bp_r", 32'(bus.remainder), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_post_ov", 32'(bus.out_valid), 32'd0);
    chk("bp_post_rdy", 32'(bus.in_ready), 32'd1);
    accept_wait(lat, rs);
    chk("bp2_lat", 32'(lat), 32'd16);
    chk("bp2_q", 32'(bus.quotient), 32'd15);
    chk("bp2_r", 32'(bus.remainder), 32'd2);
    consume("bp2");

    // reset in the 7th busy cycle
    drive(5000, 3);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    chk("mid_busy", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_ov", 32'(bus.out_valid), 32'd0);
    chk("mid_rdy", 32'(bus.in_ready), 32'd1);
    chk("mid_q", 32'(bus.quotient), 32'd0);
    chk("mid_r", 32'(bus.remainder), 32'd0);
    chk("mid_dbz", 32'(bus.div_by_zero), 32'd0);
    op("mid_redo", 5000, 3, 1666, 2, 0, 16);

    // multiplier round trip
    op("rt_200_123", 24600, 123, 200, 0, 0, 16);
    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(127, 0));
      b = int'($urandom_range(255, 1));
      op("rt_rand", a * b, b, a, 0, 0, small_lat(a * b, b));
    end

    // general division, invariant check
    for (int i = 0; i < 6; i++) begin
      d = int'($urandom_range(32767, 0));
      b = int'($urandom_range(255, 1));
      drive(d, b);
      accept_wait(lat, rs);
      q = int'(bus.quotient);
      r = int'(bus.remainder);
      chk("inv_ov", 32'(bus.out_valid), 32'd1);
      chk("inv_q", 32'(q), 32'(d / b));
      chk("inv_prod", 32'(q * b + r), 32'(d));
      chk("inv_rlt", 32'(r < b), 32'd1);
      consume("inv");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
